// File: rtl/pipe_skid_16b.sv
// Two-entry registered skid buffer for a 16-bit valid/ready stream with synchronous flush.
// in_ready is decoded from registered state, so it never depends on out_ready combinationally.
module pipe_skid_16b #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept;
    logic             emit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        out_valid = (state_q != StEmpty);
        in_ready  = (state_q != StFull);
        case (state_q)
            StBusy:  occupancy = 2'd1;
            StFull:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign out_data = main_q;
    assign accept   = in_valid & in_ready;
    assign emit     = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StBusy;
                    main_d  = in_data;
                end
            end
            StBusy: begin
                if (accept && !emit) begin
                    state_d = StFull;
                    skid_d  = in_data;
                end else if (accept && emit) begin
                    main_d = in_data;
                end else if (emit) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (emit) begin
                    state_d = StBusy;
                    main_d  = skid_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush wins: any same-cycle accepted word is dropped without touching the data regs.
        if (flush) begin
            state_d = StEmpty;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

endmodule

// File: tb/tb_pipe_skid_16b.sv
// Directed and constrained-random checks of pipe_skid_16b against a queue reference model.
module tb_pipe_skid_16b;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  occupancy;

    int n_cmp;
    int n_err;

    logic [15:0] q[$];
    logic        acc;
    logic        em;
    logic        hold;
    logic [15:0] hold_data;

    pipe_skid_16b #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        hold      = 1'b0;
        hold_data = '0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset values
        #3;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_data", 32'(out_data), 32'h0);
        check_eq("rst_occupancy", 32'(occupancy), 32'd0);
        step();
        rst = 1'b1;

        // 1: single word latency
        in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("t1_out_valid", 32'(out_valid), 32'd1);
        check_eq("t1_out_data", 32'(out_data), 32'h1234);
        check_eq("t1_in_ready", 32'(in_ready), 32'd1);
        check_eq("t1_occupancy", 32'(occupancy), 32'd1);
        step();
        check_eq("t1_drained", 32'(occupancy), 32'd0);

        // 2: backpressure fills both entries
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'hAAAA;
        step();
        in_data = 16'hBBBB;
        step();
        in_valid = 1'b0;
        check_eq("t2_occupancy", 32'(occupancy), 32'd2);
        check_eq("t2_in_ready", 32'(in_ready), 32'd0);
        check_eq("t2_data_held", 32'(out_data), 32'hAAAA);
        step();
        check_eq("t2_data_held2", 32'(out_data), 32'hAAAA);
        out_ready = 1'b1;
        step();
        check_eq("t2_second", 32'(out_data), 32'hBBBB);
        check_eq("t2_second_valid", 32'(out_valid), 32'd1);
        step();
        check_eq("t2_empty", 32'(out_valid), 32'd0);

        // 3: full-rate streaming
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 16'(i);
            step();
            check_eq("t3_valid", 32'(out_valid), 32'd1);
            check_eq("t3_data", 32'(out_data), 32'(i));
            check_eq("t3_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check_eq("t3_empty", 32'(occupancy), 32'd0);

        // 4: flush while full with a pending producer word
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'hC0DE;
        step();
        in_data = 16'hBEEF;
        step();
        check_eq("t4_full", 32'(occupancy), 32'd2);
        in_data = 16'h5555; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("t4_out_valid", 32'(out_valid), 32'd0);
        check_eq("t4_occupancy", 32'(occupancy), 32'd0);
        check_eq("t4_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t4_no_emit", 32'(out_valid), 32'd0);
        end

        // 5: async reset while full
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h1111;
        step();
        in_data = 16'h2222;
        step();
        in_valid = 1'b0;
        check_eq("t5_full", 32'(occupancy), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check_eq("t5_out_valid", 32'(out_valid), 32'd0);
        check_eq("t5_out_data", 32'(out_data), 32'h0);
        check_eq("t5_in_ready", 32'(in_ready), 32'd1);
        check_eq("t5_occupancy", 32'(occupancy), 32'd0);
        #2;
        rst = 1'b1;
        step();
        check_eq("t5_post_rst", 32'(out_valid), 32'd0);

        // 6: random traffic against a queue model
        q.delete();
        for (int c = 0; c < 2000; c++) begin
            in_valid  = 1'($urandom_range(1));
            out_ready = 1'($urandom_range(1));
            in_data   = 16'($urandom);
            flush     = ($urandom_range(99) < 2);
            check_eq("r_in_ready", 32'(in_ready), 32'(q.size() < 2));
            check_eq("r_out_valid", 32'(out_valid), 32'(q.size() != 0));
            check_eq("r_occupancy", 32'(occupancy), 32'(q.size()));
            if (q.size() != 0) check_eq("r_data", 32'(out_data), 32'(q[0]));
            if (hold) check_eq("r_stable", 32'(out_data), 32'(hold_data));
            acc       = in_valid && (q.size() < 2);
            em        = (q.size() != 0) && out_ready;
            hold      = (q.size() != 0) && !out_ready && !flush;
            hold_data = (q.size() != 0) ? q[0] : 16'h0;
            step();
            if (flush) begin
                q.delete();
            end else begin
                if (em) void'(q.pop_front());
                if (acc) q.push_back(in_data);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
